muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// One radix-2 step per cycle on operand magnitudes. Multiply is shift-add
// into a 64-bit {acc_hi, acc_lo} product. Divide is restoring, with the
// remainder in acc_hi and the quotient shifting into acc_lo. Signs are
// applied in a single FIX cycle. Divide-by-zero and signed overflow skip
// the iteration and go through SPECIAL instead.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   M-extension op present in execute; sampled each edge
//   flush   execute-stage flush; aborts any op, wins over start
//   funct3  op select (MUL..REMU)
//   op_a    rs1 operand
//   op_b    rs2 operand
//   rd_in   destination tag
//   stall   combinational freeze request to the hazard unit
//   done    one-cycle pulse, result valid
//   result  registered result, held until next done
//   rd_out  registered tag, held until next done
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; latches operands on start & !flush
// CALC    | 32 radix-2 iterations, counter 0..31
// FIX     | sign correction and result select
// SPECIAL | divide-by-zero / signed-overflow result, no iteration
// DONE    | done pulse; start ignored, back to IDLE next edge
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FIX     = 3'd2,
        SPECIAL = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [2:0]  f3;
    logic [31:0] a_reg;
    logic [31:0] mag_b;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        neg_a;
    logic        neg_b;
    logic [4:0]  rd_lat;

    // Operand decode at the start edge
    logic        in_signed_a;
    logic        in_signed_b;
    logic        in_neg_a;
    logic        in_neg_b;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic        in_special;

    always_comb begin
        in_signed_a = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        in_signed_b = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        in_neg_a    = in_signed_a && op_a[31];
        in_neg_b    = in_signed_b && op_b[31];
        in_mag_a    = in_neg_a ? (32'd0 - op_a) : op_a;
        in_mag_b    = in_neg_b ? (32'd0 - op_b) : op_b;
        // Only signed DIV/REM (funct3[0]=0) can overflow
        in_special  = funct3[2] &&
                      ((op_b == 32'd0) ||
                       (!funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)));
    end

    // One iteration step for each operation class
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nxt;
    logic [31:0] mul_lo_nxt;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_hi_nxt;
    logic [31:0] div_lo_nxt;

    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);
        mul_hi_nxt = mul_sum[32:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[31:1]};

        rem_sh     = {acc_hi, acc_lo[31]};
        div_diff   = rem_sh - {1'b0, mag_b};
        // Remainder stays below the divisor, so bit 32 of the difference is
        // exactly the borrow of the trial subtraction.
        div_ge     = !div_diff[32];
        div_hi_nxt = div_ge ? div_diff[31:0] : rem_sh[31:0];
        div_lo_nxt = {acc_lo[30:0], div_ge};
    end

    // Sign correction and result select
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;
    logic [31:0] special_result;

    always_comb begin
        neg_res  = neg_a ^ neg_b;
        prod_fix = neg_res ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
        quo_fix  = neg_res ? (32'd0 - acc_lo) : acc_lo;
        rem_fix  = neg_a ? (32'd0 - acc_hi) : acc_hi;
        case (f3)
            3'b000:                  fix_result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011:  fix_result = prod_fix[63:32];
            3'b100, 3'b101:          fix_result = quo_fix;
            default:                 fix_result = rem_fix;
        endcase

        // f3[1] separates REM/REMU from DIV/DIVU
        if (mag_b == 32'd0)
            special_result = f3[1] ? a_reg : 32'hFFFF_FFFF;
        else
            special_result = f3[1] ? 32'd0 : 32'h8000_0000;
    end

    always_comb begin
        stall = !rst && (((state == IDLE) && start && !flush) ||
                         (state == CALC) || (state == FIX) || (state == SPECIAL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 5'd0;
            f3     <= 3'd0;
            a_reg  <= 32'd0;
            mag_b  <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            rd_lat <= 5'd0;
            done   <= 1'b0;
            result <= 32'd0;
            rd_out <= 5'd0;
        end else if (flush) begin
            state <= IDLE;
            count <= 5'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        f3     <= funct3;
                        a_reg  <= op_a;
                        mag_b  <= in_mag_b;
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        rd_lat <= rd_in;
                        acc_hi <= 32'd0;
                        acc_lo <= in_mag_a;
                        count  <= 5'd0;
                        state  <= in_special ? SPECIAL : CALC;
                    end
                end
                CALC: begin
                    if (f3[2]) begin
                        acc_hi <= div_hi_nxt;
                        acc_lo <= div_lo_nxt;
                    end else begin
                        acc_hi <= mul_hi_nxt;
                        acc_lo <= mul_lo_nxt;
                    end
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_result;
                    rd_out <= rd_lat;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                SPECIAL: begin
                    result <= special_result;
                    rd_out <= rd_lat;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          ia, ib;
        bit          ovf;
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sa  = (f == 3'b011) ? longint'({32'd0, a}) : longint'(ia);
        sb  = (f == 3'b010 || f == 3'b011) ? longint'({32'd0, b}) : longint'(ib);
        p   = 64'(sa * sb);
        case (f)
            3'b000:  return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // One complete op; optionally scrambles inputs and toggles start while busy.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noisy);
        int          n;
        int          stall_cyc;
        int          exp_lat;
        logic [31:0] exp_res;
        exp_res = ref_result(f, a, b);
        exp_lat = ref_special(f, a, b) ? 2 : 34;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1; flush = 1'b0;
        #1;
        stall_cyc = int'(stall);
        @(posedge clk);
        n = 1;
        #1;
        while (!done && n < 60) begin
            @(negedge clk);
            stall_cyc += int'(stall);
            if (noisy) begin
                start  = 1'($urandom_range(0, 1));
                funct3 = 3'($urandom_range(0, 7));
                op_a   = $urandom;
                op_b   = $urandom;
                rd_in  = 5'($urandom_range(0, 31));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            #1;
        end
        check("latency", n, exp_lat);
        check("stall_cycles", stall_cyc, exp_lat);
        check("result", result, exp_res);
        check("rd_out", rd_out, {27'd0, rd});
        check("stall_in_done", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        start = 1'b0;
        #1;
        check("start_in_done_ignored", {31'd0, stall}, 32'd0);
    endtask

    task automatic flush_test();
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        prev_res = result;
        prev_rd  = rd_out;
        @(negedge clk);
        funct3 = 3'b100; op_a = $urandom; op_b = 32'd5; rd_in = 5'd17; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_result_held", result, prev_res);
        check("flush_rd_held", {27'd0, rd_out}, {27'd0, prev_rd});
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd18, 1'b0);
    endtask

    task automatic reset_test();
        int seen;
        run_op(3'b101, 32'd100, 32'd7, 5'd3, 1'b0);
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_result", result, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen += int'(done);
        end
        check("rst_abort_no_done", seen, 0);
        run_op(3'b000, 32'd3, 32'd4, 5'd11, 1'b0);
    endtask

    initial begin
        start = 1'b1;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
        check("mul_7_m3", result, 32'hFFFF_FFEB);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b1);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
        run_op(3'b101, 32'd100, 32'd7, 5'd7, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 5'd8, 1'b0);
        run_op(3'b101, 32'd100, 32'd0, 5'd9, 1'b0);
        run_op(3'b111, 32'd100, 32'd0, 5'd10, 1'b1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        flush_test();
        reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
